// File: rtl/i2c_mon_pkg.sv
// Shared event/slot types and the elaboration-time SCL period limit helper
// for the multi-bus I2C monitor.
package i2c_mon_pkg;

  localparam int PERIOD_W = 16;

  typedef enum logic [1:0] {
    EV_START     = 2'd0,
    EV_RSTART    = 2'd1,
    EV_STOP      = 2'd2,
    EV_RATE_VIOL = 2'd3
  } i2c_mon_ev_t;

  typedef struct packed {
    i2c_mon_ev_t         t;
    logic [PERIOD_W-1:0] p;
  } i2c_mon_slot_t;

  // Shortest legal SCL period in clk cycles; a zero rate disables the check.
  function automatic int min_period(input int clk_khz, input int rate_khz);
    return (rate_khz > 0) ? (clk_khz / rate_khz) : 0;
  endfunction

endpackage

// File: rtl/i2c_mon_chan.sv
// One monitored bus: sync (+ majority filter under I2C_MON_GLITCH_FILTER_EN), START/RSTART/STOP
// detection, SCL period check and a depth-1 pending slot; a new event with the slot held drops and sets overflow.
module i2c_mon_chan
  import i2c_mon_pkg::*;
#(
  parameter int MIN_PERIOD = 250
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          scl_i,
  input  logic          sda_i,
  input  logic          grant_i,
  output logic          slot_full_o,
  output i2c_mon_slot_t slot_o,
  output logic          busy_o,
  output logic          overflow_o
);

  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  // Bit 1 carries SCL, bit 0 carries SDA; everything resets to the idle-high level.
  logic [1:0] meta_q, meta_d, sync_q, sync_d, hist_q, hist_d, cur;
  logic       busy_q, busy_d, seen_q, seen_d, slot_full_q, slot_full_d, ovf_q, ovf_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  i2c_mon_slot_t slot_q, slot_d, ev_slot;
  logic       ev, start, stop, scl_rise;

`ifdef I2C_MON_GLITCH_FILTER_EN
  logic [1:0] dly0_q, dly0_d, dly1_q, dly1_d, filt_q, filt_d;

  always_comb begin
    dly0_d = sync_q;
    dly1_d = dly0_q;
    filt_d = (sync_q & dly0_q) | (sync_q & dly1_q) | (dly0_q & dly1_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dly0_q <= '1;
      dly1_q <= '1;
      filt_q <= '1;
    end else begin
      dly0_q <= dly0_d;
      dly1_q <= dly1_d;
      filt_q <= filt_d;
    end
  end

  assign cur = filt_q;
`else
  assign cur = sync_q;
`endif

  assign start    =  hist_q[0] & ~cur[0] & hist_q[1] & cur[1];
  assign stop     = ~hist_q[0] &  cur[0] & hist_q[1] & cur[1];
  assign scl_rise = ~hist_q[1] &  cur[1];

  always_comb begin
    meta_d      = {scl_i, sda_i};
    sync_d      = meta_q;
    hist_d      = cur;
    busy_d      = busy_q;
    seen_d      = seen_q;
    cnt_d       = cnt_q;
    ev          = 1'b0;
    ev_slot     = '0;
    slot_full_d = slot_full_q;
    slot_d      = slot_q;
    ovf_d       = ovf_q;

    if (start) begin
      ev        = 1'b1;
      ev_slot.t = busy_q ? EV_RSTART : EV_START;
      busy_d    = 1'b1;
      seen_d    = 1'b0;
      cnt_d     = '0;
    end else if (stop) begin
      ev        = 1'b1;
      ev_slot.t = EV_STOP;
      busy_d    = 1'b0;
      seen_d    = 1'b0;
      cnt_d     = '0;
    end else if (busy_q) begin
      if (scl_rise) begin
        // The first rise after START only anchors the measurement.
        if (seen_q && (cnt_q < MIN_P)) begin
          ev        = 1'b1;
          ev_slot.t = EV_RATE_VIOL;
          ev_slot.p = cnt_q;
        end
        seen_d = 1'b1;
        cnt_d  = PERIOD_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (grant_i) slot_full_d = 1'b0;
    if (ev) begin
      if (slot_full_q && !grant_i) begin
        ovf_d = 1'b1;
      end else begin
        slot_full_d = 1'b1;
        slot_d      = ev_slot;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q      <= '1;
      sync_q      <= '1;
      hist_q      <= '1;
      busy_q      <= 1'b0;
      seen_q      <= 1'b0;
      cnt_q       <= '0;
      slot_full_q <= 1'b0;
      slot_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      busy_q      <= busy_d;
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
      slot_full_q <= slot_full_d;
      slot_q      <= slot_d;
      ovf_q       <= ovf_d;
    end
  end

  assign slot_full_o = slot_full_q;
  assign slot_o      = slot_q;
  assign busy_o      = busy_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/i2c_multibus_monitor.sv
// Passive N-bus I2C monitor: per-bus channels merged by a round-robin arbiter into one registered
// valid/ready stream; pin-to-valid 4 cycles (6 with I2C_MON_GLITCH_FILTER_EN); output holds while stalled.
module i2c_multibus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int NUM_BUSSES        = 16,
  parameter int CLK_FREQ_KHZ      = 100000,
  parameter int BUS_RATES_KHZ [16] = '{400, 350, 300, 250, 200, 150, 100, 90,
                                      80, 72, 60, 50, 42, 35, 30, 100},
  parameter int PERIOD_WIDTH      = PERIOD_W,
  localparam int BW               = (NUM_BUSSES > 1) ? $clog2(NUM_BUSSES) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_BUSSES-1:0]   scl_i,
  input  logic [NUM_BUSSES-1:0]   sda_i,
  output logic                    ev_valid_o,
  input  logic                    ev_ready_i,
  output logic [BW-1:0]           ev_bus_o,
  output i2c_mon_ev_t             ev_type_o,
  output logic [PERIOD_WIDTH-1:0] ev_period_o,
  output logic [NUM_BUSSES-1:0]   bus_busy_o,
  output logic [NUM_BUSSES-1:0]   overflow_o
);

  logic [NUM_BUSSES-1:0]   slot_full, grant;
  i2c_mon_slot_t           slot [NUM_BUSSES];

  logic                    valid_q, valid_d;
  logic [BW-1:0]           bus_q, bus_d, rr_q, rr_d, gnt_idx, idx;
  i2c_mon_ev_t             type_q, type_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    gnt_found;

  for (genvar g = 0; g < NUM_BUSSES; g++) begin : g_chan
    i2c_mon_chan #(
      .MIN_PERIOD(min_period(CLK_FREQ_KHZ, BUS_RATES_KHZ[g]))
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .scl_i      (scl_i[g]),
      .sda_i      (sda_i[g]),
      .grant_i    (grant[g]),
      .slot_full_o(slot_full[g]),
      .slot_o     (slot[g]),
      .busy_o     (bus_busy_o[g]),
      .overflow_o (overflow_o[g])
    );
  end

  always_comb begin
    valid_d   = valid_q;
    bus_d     = bus_q;
    type_d    = type_q;
    period_d  = period_q;
    rr_d      = rr_q;
    grant     = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;

    // First full slot at or after the pointer, wrapping.
    for (int k = 0; k < NUM_BUSSES; k++) begin
      idx = BW'((int'(rr_q) + k) % NUM_BUSSES);
      if (!gnt_found && slot_full[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end

    if (!valid_q || ev_ready_i) begin
      valid_d = gnt_found;
      if (gnt_found) begin
        grant[gnt_idx] = 1'b1;
        bus_d          = gnt_idx;
        type_d         = slot[gnt_idx].t;
        period_d       = PERIOD_WIDTH'(slot[gnt_idx].p);
        rr_d           = (int'(gnt_idx) == NUM_BUSSES - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      bus_q    <= '0;
      type_q   <= EV_START;
      period_q <= '0;
      rr_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      bus_q    <= bus_d;
      type_q   <= type_d;
      period_q <= period_d;
      rr_q     <= rr_d;
    end
  end

  assign ev_valid_o  = valid_q;
  assign ev_bus_o    = bus_q;
  assign ev_type_o   = type_q;
  assign ev_period_o = period_q;

endmodule
